mem_bus_arbiter: RTL

- Arbitrates the single-port core memory (mems) between the instruction-fetch port and the EXU load/store port.
- Allows one outstanding transaction at a time and has a fixed memory latency.
- Gives EX priority, with a starvation guard for IF.
- Drives a hold request to ctrl whenever a requester is waiting. It sits between pc_reg/exu and mems, and replaces the direct fetch/data muxing into mems.

---
 rtl/mem_bus_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates single-port core memory between IF fetch and EX load/store; EX priority, optional IF starve guard (MEM_ARB_STARVE_GUARD_EN).
// Latency: grant combinational in the slot cycle, rvalid MEM_LAT cycles after grant; one outstanding transaction.
// Backpressure: losers hold req until gnt; hold_flag_o stalls ctrl while any request waits.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ex_req_i,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    output logic              ex_gnt_o,
    output logic              ex_rvalid_o,
    output logic [DATA_W-1:0] ex_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              hold_flag_o
);

    if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
        $error("mem_bus_arbiter: MEM_LAT must be 1..7 and STARVE_MAX 1..15");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_EX = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_t     state;
    logic [2:0] lat_cnt;
    logic       ex_wr;

    logic busy, completing, slot, force_if, if_win, ex_win;

    assign busy       = (state != IDLE);
    assign completing = busy && (lat_cnt == LAT_LAST);
    // The completing cycle doubles as an arbitration slot so MEM_LAT=1 sustains one access per cycle.
    assign slot       = !busy || completing;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    assign force_if = (starve_cnt == STARVE_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!if_req_i || if_win) begin
            starve_cnt <= '0;
        end else if (slot && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign if_win = slot && if_req_i && (!ex_req_i || force_if);
    assign ex_win = slot && ex_req_i && !if_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
            ex_wr   <= 1'b0;
        end else if (if_win) begin
            state   <= BUSY_IF;
            lat_cnt <= '0;
            ex_wr   <= 1'b0;
        end else if (ex_win) begin
            state   <= BUSY_EX;
            lat_cnt <= '0;
            ex_wr   <= ex_we_i;
        end else if (completing) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else if (busy) begin
            lat_cnt <= lat_cnt + 3'd1;
        end
    end

    // Request-derived outputs are gated by rst so every output reads 0 while reset is held.
    assign if_gnt_o    = rst && if_win;
    assign ex_gnt_o    = rst && ex_win;
    assign mem_req_o   = if_gnt_o || ex_gnt_o;
    assign mem_we_o    = ex_gnt_o && ex_we_i;
    assign mem_addr_o  = ex_gnt_o ? ex_addr_i : (if_gnt_o ? if_addr_i : '0);
    assign mem_wdata_o = ex_gnt_o ? ex_wdata_i : '0;

    assign if_rvalid_o = completing && (state == BUSY_IF);
    assign ex_rvalid_o = completing && (state == BUSY_EX);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign ex_rdata_o  = (ex_rvalid_o && !ex_wr) ? mem_rdata_i : '0;

    assign hold_flag_o = rst && ((if_req_i && !if_gnt_o) || (ex_req_i && !ex_gnt_o));

endmodule
